// File: rtl/serial_adder_seq.sv
// Bit-serial LSB-first adder: full adder from two half adders, carry kept in a flop between bit cycles.
// Latency WIDTH cycles from accept to result valid; operands refused in SHIFT/DONE, result held until res_ready_in.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             op_valid_in,
    output logic             op_ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             busy_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_cy;
    logic             r_carry;
    logic             r_op_rdy;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_s;
    logic             w_ha2_c;
    logic             w_cy_nxt;
    logic [WIDTH-1:0] w_sum_sh_nxt;

    // Two half-adder stages form the full adder for the current bit pair.
    assign w_ha1_s      = r_a_sh[0] ^ r_b_sh[0];
    assign w_ha1_c      = r_a_sh[0] & r_b_sh[0];
    assign w_s          = w_ha1_s ^ r_cy;
    assign w_ha2_c      = w_ha1_s & r_cy;
    assign w_cy_nxt     = w_ha1_c | w_ha2_c;
    assign w_sum_sh_nxt = {w_s, r_sum_sh[WIDTH-1:1]};

    assign w_accept = (r_state == ST_IDLE) && op_valid_in && r_op_rdy;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)     w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)       w_state_nxt = ST_DONE;
            ST_DONE:  if (res_ready_in) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready is registered so it stays low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_op_rdy <= 1'b0;
        end else begin
            r_op_rdy <= (w_state_nxt == ST_IDLE);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_cy     <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_sh <= a_in;
                r_b_sh <= b_in;
                r_cy   <= cin_in;
                r_cnt  <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_cy     <= w_cy_nxt;
                r_sum_sh <= w_sum_sh_nxt;
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_sum   <= w_sum_sh_nxt;
                    r_carry <= w_cy_nxt;
                end
            end
        end
    end

    assign op_ready_out  = r_op_rdy;
    assign res_valid_out = (r_state == ST_DONE);
    assign busy_out      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign sum_out       = r_sum;
    assign carry_out     = r_carry;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq at WIDTH=8 and WIDTH=16: directed cases plus randomised scoreboard traffic.
module tb_serial_adder_seq;

    logic        clk;
    logic        rst_n;

    logic        v8, rdy8, c8, rv8, rr8, co8, busy8;
    logic [7:0]  a8, b8, s8;
    logic        v16, rdy16, c16, rv16, rr16, co16, busy16;
    logic [15:0] a16, b16, s16;

    int total = 0;
    int bad   = 0;
    int sent8 = 0, got8 = 0, sent16 = 0, got16 = 0;
    bit done8 = 0, done16 = 0;

    logic [16:0] q8[$];
    logic [16:0] q16[$];
    logic [16:0] e8, e16;

    serial_adder_seq #(.WIDTH(8)) u_dut8 (
        .clk_in(clk), .rst_n_in(rst_n),
        .op_valid_in(v8), .op_ready_out(rdy8),
        .a_in(a8), .b_in(b8), .cin_in(c8),
        .res_valid_out(rv8), .res_ready_in(rr8),
        .sum_out(s8), .carry_out(co8), .busy_out(busy8)
    );

    serial_adder_seq #(.WIDTH(16)) u_dut16 (
        .clk_in(clk), .rst_n_in(rst_n),
        .op_valid_in(v16), .op_ready_out(rdy16),
        .a_in(a16), .b_in(b16), .cin_in(c16),
        .res_valid_out(rv16), .res_ready_in(rr16),
        .sum_out(s16), .carry_out(co16), .busy_out(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitors: a transfer is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (rst_n && rv8 && rr8) begin
            if (q8.size() == 0) chk("m8_extra", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                chk("m8_res", 32'({co8, s8}), 32'(e8));
            end
            got8++;
        end
        if (rst_n && rv16 && rr16) begin
            if (q16.size() == 0) chk("m16_extra", 32'd1, 32'd0);
            else begin
                e16 = q16.pop_front();
                chk("m16_res", 32'({co16, s16}), 32'(e16));
            end
            got16++;
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        @(posedge clk); #1;
        a8 = a; b8 = b; c8 = c; v8 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy8 && n < 300) begin @(negedge clk); n++; end
        if (!rdy8) chk("acc8_timeout", 32'd0, 32'd1);
        else begin
            q8.push_back(17'(a) + 17'(b) + 17'(c));
            sent8++;
        end
        @(posedge clk); #1;
        v8 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n;
        @(posedge clk); #1;
        a16 = a; b16 = b; c16 = c; v16 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy16 && n < 300) begin @(negedge clk); n++; end
        if (!rdy16) chk("acc16_timeout", 32'd0, 32'd1);
        else begin
            q16.push_back(17'(a) + 17'(b) + 17'(c));
            sent16++;
        end
        @(posedge clk); #1;
        v16 = 1'b0;
    endtask

    task automatic wait_rv8();
        int n = 0;
        while (!rv8 && n < 100) begin @(posedge clk); #1; n++; end
        if (!rv8) chk("rv8_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while ((rv8 || busy8) && n < 300) begin @(posedge clk); #1; n++; end
        if (rv8 || busy8) chk("idle8_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle16();
        int n = 0;
        while ((rv16 || busy16) && n < 300) begin @(posedge clk); #1; n++; end
        if (rv16 || busy16) chk("idle16_timeout", 32'd0, 32'd1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input string tag);
        send8(a, b, c);
        wait_rv8();
        chk({tag, "_sum"}, 32'(s8), 32'(es));
        chk({tag, "_cy"}, 32'(co8), 32'(ec));
        wait_idle8();
    endtask

    initial begin
        int lat, seen;
        rst_n = 1'b0;
        v8 = 0; a8 = 0; b8 = 0; c8 = 0; rr8 = 1;
        v16 = 0; a16 = 0; b16 = 0; c16 = 0; rr16 = 1;

        #12;
        chk("rst_rdy", 32'(rdy8), 32'd0);
        chk("rst_rv", 32'(rv8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_sum", 32'({co8, s8}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_rdy", 32'(rdy8), 32'd1);
        chk("rel_rv", 32'(rv8), 32'd0);
        chk("rel_busy", 32'(busy8), 32'd0);
        chk("rel_sum", 32'({co8, s8}), 32'd0);
        chk("rel_rdy16", 32'(rdy16), 32'd1);

        // Result must appear exactly WIDTH edges after acceptance.
        send8(8'h35, 8'h4A, 1'b0);
        lat = 0;
        while (!rv8 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("lat8", 32'(lat), 32'd8);
        chk("t2_sum", 32'(s8), 32'h7F);
        chk("t2_cy", 32'(co8), 32'd0);
        wait_idle8();

        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t3a");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3b");
        run8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "t3c");
        chk("hold_idle_sum", 32'(s8), 32'h01);

        // Consumer stall in DONE with a new request pending.
        rr8 = 1'b0;
        send8(8'h12, 8'h34, 1'b0);
        wait_rv8();
        a8 = 8'h56; b8 = 8'h78; c8 = 1'b1; v8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4_sum", 32'(s8), 32'h46);
            chk("t4_rv", 32'(rv8), 32'd1);
            chk("t4_rdy", 32'(rdy8), 32'd0);
        end
        rr8 = 1'b1;
        @(posedge clk); #1;
        chk("t4_bubble_rv", 32'(rv8), 32'd0);
        chk("t4_bubble_rdy", 32'(rdy8), 32'd1);
        chk("t4_bubble_busy", 32'(busy8), 32'd0);
        q8.push_back(17'h0CF);
        sent8++;
        @(posedge clk); #1;
        chk("t4_acc_busy", 32'(busy8), 32'd1);
        chk("t4_acc_rdy", 32'(rdy8), 32'd0);
        v8 = 1'b0;
        wait_rv8();
        chk("t4_new_sum", 32'({co8, s8}), 32'h0CF);
        wait_idle8();

        // Abort mid-SHIFT: outputs clear immediately and the operation never completes.
        send8(8'h11, 8'h22, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rdy", 32'(rdy8), 32'd0);
        chk("t5_rv", 32'(rv8), 32'd0);
        chk("t5_busy", 32'(busy8), 32'd0);
        chk("t5_sum", 32'({co8, s8}), 32'd0);
        q8.delete();
        sent8--;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rv8) seen++;
        end
        chk("t5_no_pulse", 32'(seen), 32'd0);
        chk("t5_rdy_after", 32'(rdy8), 32'd1);

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send8(8'($urandom), 8'($urandom), 1'($urandom));
                end
                wait_idle8();
                done8 = 1;
            end
            begin
                while (!done8) begin
                    @(posedge clk); #1;
                    rr8 = ($urandom_range(0, 9) < 7);
                end
                rr8 = 1'b1;
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send16(16'($urandom), 16'($urandom), 1'($urandom));
                end
                wait_idle16();
                done16 = 1;
            end
            begin
                while (!done16) begin
                    @(posedge clk); #1;
                    rr16 = ($urandom_range(0, 9) < 7);
                end
                rr16 = 1'b1;
            end
        join

        repeat (4) @(posedge clk);
        chk("q8_empty", 32'(q8.size()), 32'd0);
        chk("q16_empty", 32'(q16.size()), 32'd0);
        chk("count8", 32'(got8), 32'(sent8));
        chk("count16", 32'(got16), 32'(sent16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
